mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the EXE stage of the 5-stage pipeline.
- Executes signed and unsigned multiply and divide in multiple cycles and holds the HI/LO result registers.
- Raises a stall to the hazard unit while an operation is in flight.
- Accepts a flush from CP0 so exception handling can cancel an in-flight operation.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  EXE-stage request valid; sampled only in IDLE.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-op.
- src_a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- src_b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  cancel the in-flight operation (exception flush from CP0).
- stall  out  1  pipeline hold request to the hazard unit.
- busy  out  1  high in states MUL, DIV and FIX.
- done  out  1  one-cycle pulse when HI/LO have just been updated by mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (clock edge with reset=1): state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0, internal accumulators=0. Reset overrides start and flush in the same cycle.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start=1 with op 0-3:
  - Latch |src_a| and |src_b|; absolute value applies only to signed ops.
  - Latch the result signs: quotient/product sign = sign_a XOR sign_b; remainder sign = sign_a.
  - Next state MUL or DIV; counter=0.
- IDLE, start=1 with op 4 (MTHI) or op 5 (MTLO): hi or lo <= src_a at that edge, single cycle, stall stays 0, no done pulse.
- IDLE, start=1 with op 6 or 7: ignored.
- MUL: shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle.
- DIV: restoring division, one quotient bit per cycle.
- Both MUL and DIV run exactly WIDTH cycles; when the counter reaches WIDTH-1 the next state is FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Write {hi,lo} = product, or hi = remainder and lo = quotient.
  - Next state DONE.
- DONE: done=1 for this one cycle; next state IDLE. start is not accepted in DONE.
- Latency: done is high exactly WIDTH+2 cycles after the accepting edge; for WIDTH=32 that is 34 cycles. hi/lo show the new values in the same cycle done is high.
- stall = busy | (state==IDLE & start & op<=3). The requesting instruction is therefore held in EXE from its first cycle until DONE.
- start while busy or in DONE: ignored; the hazard unit guarantees no issue in these states.
- Divide by zero (src_b=0), fixed result: lo = all ones, hi = src_a unmodified. Both signed and unsigned; full latency still applies.
- Signed overflow (DIV with src_a = -2^(WIDTH-1), src_b = -1): lo = -2^(WIDTH-1), hi = 0.
- Most-negative operands in MULT: the magnitude is taken as an unsigned WIDTH-bit value, so the result is exact. Example: 0x80000000 * 0x80000000 gives hi=0x40000000, lo=0.
- flush=1 in MUL, DIV or FIX:
  - Next state IDLE; hi/lo unchanged; no done pulse; stall drops on the next cycle.
  - flush in DONE has no effect, since hi/lo are already committed.
  - flush in IDLE also blocks a same-cycle start, including MTHI/MTLO.
- hi/lo are modified only by FIX, MTHI, MTLO and reset.

Test Plan:
- Reset mid-DIV at iteration 10 -> next cycle state=IDLE, hi=lo=0, busy=stall=done=0.
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> done 34 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall high during cycles 0..33, low in the done cycle.
- DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678 after 34 cycles.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF with flush asserted in iteration 20 -> IDLE next cycle, no done pulse, hi/lo keep their prior values.
- MTHI 0xDEADBEEF, then MTLO 0x1 back-to-back -> hi=0xDEADBEEF and lo=1 after two edges, stall=0 throughout. MTLO issued while busy -> ignored, lo unchanged.

Source files
------------

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative signed/unsigned multiply/divide unit with HI/LO registers
//
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start, op       : request valid and opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO)
//   src_a, src_b    : rs / rt operands
//   flush           : cancel any in-flight operation
//   stall, busy     : pipeline hold request / operation in flight
//   done            : one-cycle pulse after HI/LO are written by a mul/div
//   hi, lo          : architectural HI/LO registers
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier bits}
    // DIV: {partial remainder, dividend bits shifting out / quotient bits shifting in}
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Multiplicand magnitude for MUL, divisor magnitude for DIV
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 neg_q, neg_d;     // product / quotient sign
    logic                 rneg_q, rneg_d;   // remainder sign (dividend sign)
    logic                 is_div_q, is_div_d;
    logic                 dz_q, dz_d;       // divide by zero
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 signed_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_fix;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op & src_a[WIDTH-1];
        b_neg     = signed_op & src_b[WIDTH-1];
        // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -src_b : src_b;

        mul_sum   = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        prod_fix  = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d = op[1];
                            acc_d    = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                            opnd_d   = op[1] ? b_mag : a_mag;
                            neg_d    = a_neg ^ b_neg;
                            rneg_d   = a_neg;
                            dz_d     = (src_b == '0);
                            cnt_d    = '0;
                            state_d  = op[1] ? S_DIV : S_MUL;
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) state_d = S_FIX;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    // Restoring step: keep the difference only if no borrow occurred
                    if (!div_diff[WIDTH])
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        // With a zero divisor the remainder equals the dividend magnitude,
                        // so re-applying the dividend sign restores src_a exactly.
                        hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                        lo_d = dz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy  = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign stall = busy || ((state_q == S_IDLE) && start && (op <= OP_DIVU));
    assign done  = (state_q == S_DONE);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
